// File: rtl/expansion_port_fifo.sv
// expansion_port_fifo
// Peripheral-side responder for one CPU expansion port. CPU data writes fill
// a TX FIFO that drains to a device over valid/ready. Device words fill an RX
// FIFO that the CPU pops by reading the data register. A status register
// reports both fill levels and two sticky error flags. The shared 16-bit bus
// is driven only while oe is high.
module expansion_port_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        r,
    inout  wire  [15:0] bus,
    input  logic        we,
    input  logic        oe,
    input  logic        sel,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

    // FIFO storage; contents are don't-care after reset, so no reset on it
    logic [15:0]   r_tx_mem [DEPTH];
    logic [15:0]   r_rx_mem [DEPTH];

    logic [AW-1:0] r_tx_wr_ptr;
    logic [AW-1:0] r_tx_rd_ptr;
    logic [3:0]    r_tx_count;
    logic [AW-1:0] r_rx_wr_ptr;
    logic [AW-1:0] r_rx_rd_ptr;
    logic [3:0]    r_rx_count;
    logic          r_tx_overflow;
    logic          r_rx_underflow;

    logic          w_cpu_wr;
    logic          w_tx_push_req;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_tx_ovf_evt;
    logic          w_rx_push;
    logic          w_rx_pop_req;
    logic          w_rx_pop;
    logic          w_rx_udf_evt;
    logic          w_ctrl_wr;
    logic          w_clear;
    logic          w_flush;
    logic          w_tx_empty;
    logic          w_rx_empty;
    logic [15:0]   w_rx_head;
    logic [15:0]   w_status;
    logic [15:0]   w_rd_word;

    // A write strobe while oe is high is ignored: only the read acts
    assign w_cpu_wr      = we & ~oe;
    assign w_tx_push_req = w_cpu_wr & ~sel;
    assign w_ctrl_wr     = w_cpu_wr & sel;
    assign w_clear       = w_ctrl_wr & bus[0];
    assign w_flush       = w_ctrl_wr & bus[1];

    assign w_tx_empty    = (r_tx_count == 4'd0);
    assign w_rx_empty    = (r_rx_count == 4'd0);

    // A full TX FIFO still accepts a word when the head leaves on the same edge
    assign w_tx_pop      = ~w_tx_empty & tx_ready;
    assign w_tx_push     = w_tx_push_req & ((r_tx_count < FULL_COUNT) | w_tx_pop);
    assign w_tx_ovf_evt  = w_tx_push_req & ~w_tx_push;

    assign w_rx_push     = rx_valid & rx_ready;
    assign w_rx_pop_req  = oe & ~sel;
    assign w_rx_pop      = w_rx_pop_req & ~w_rx_empty;
    assign w_rx_udf_evt  = w_rx_pop_req & w_rx_empty;

    // Outputs derived purely from registered state
    assign tx_valid  = ~w_tx_empty;
    assign tx_data   = w_tx_empty ? 16'h0000 : r_tx_mem[r_tx_rd_ptr];
    assign rx_ready  = (r_rx_count < FULL_COUNT);
    assign w_rx_head = w_rx_empty ? 16'h0000 : r_rx_mem[r_rx_rd_ptr];
    assign w_status  = {r_tx_overflow, r_rx_underflow, 6'd0, r_rx_count, r_tx_count};
    assign w_rd_word = sel ? w_status : w_rx_head;
    assign bus       = oe ? w_rd_word : 16'hzzzz;

    // TX storage write
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= bus;
        end
    end

    // RX storage write
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= rx_data;
        end
    end

    // TX pointers and count; flush overrides any concurrent pop
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= 4'd0;
        end else if (w_flush) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= 4'd0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + AW'(1);
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + 4'd1;
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - 4'd1;
            end
        end
    end

    // RX pointers and count; flush overrides any concurrent device push
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= 4'd0;
        end else if (w_flush) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= 4'd0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + AW'(1);
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + 4'd1;
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - 4'd1;
            end
        end
    end

    // Sticky error flags; a clear write beats a same-edge set
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else if (w_clear) begin
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            r_tx_overflow  <= r_tx_overflow  | w_tx_ovf_evt;
            r_rx_underflow <= r_rx_underflow | w_rx_udf_evt;
        end
    end

endmodule

// File: tb/tb_expansion_port_fifo.sv
// Testbench for expansion_port_fifo: directed test-plan sequences followed by
// randomized traffic, all checked against a queue-based model every cycle.
module tb_expansion_port_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        r;
    logic        we;
    logic        oe;
    logic        sel;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic [15:0] drv_val;
    logic        drv_en;
    wire  [15:0] bus;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        rx_ready;

    always #5 clk = ~clk;

    assign bus = drv_en ? drv_val : 16'hzzzz;

    expansion_port_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .r        (r),
        .bus      (bus),
        .we       (we),
        .oe       (oe),
        .sel      (sel),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: two queues and two flags
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];
    bit          m_ovf;
    bit          m_udf;

    function automatic logic [15:0] m_status();
        return {m_ovf, m_udf, 6'd0, 4'(rx_q.size()), 4'(tx_q.size())};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model
    task automatic compare_outputs();
        logic [15:0] exp_bus;
        chk("tx_valid", {15'd0, tx_valid}, {15'd0, (tx_q.size() != 0)});
        chk("tx_data", tx_data, (tx_q.size() != 0) ? tx_q[0] : 16'h0000);
        chk("rx_ready", {15'd0, rx_ready}, {15'd0, (rx_q.size() < DEPTH)});
        if (oe) begin
            if (sel) exp_bus = m_status();
            else     exp_bus = (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
            chk("bus_read", bus, exp_bus);
        end
    endtask

    // Apply the effect of the coming rising edge to the model
    task automatic model_step();
        int  txc = tx_q.size();
        int  rxc = rx_q.size();
        bit  wr = we && !oe;
        bit  tx_pop = (txc > 0) && tx_ready;
        bit  push_req = wr && !sel;
        bit  accept = push_req && ((txc < DEPTH) || tx_pop);
        bit  ovf = push_req && !accept;
        bit  rx_push = rx_valid && (rxc < DEPTH);
        bit  rx_pop = oe && !sel && (rxc > 0);
        bit  udf = oe && !sel && (rxc == 0);
        bit  ctrl = wr && sel;
        if (ctrl && drv_val[1]) begin
            tx_q.delete();
            rx_q.delete();
        end else begin
            if (tx_pop) void'(tx_q.pop_front());
            if (accept) tx_q.push_back(drv_val);
            if (rx_pop) void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(rx_data);
        end
        if (ctrl && drv_val[0]) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = m_ovf | ovf;
            m_udf = m_udf | udf;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance model
    task automatic step(input bit i_we, input bit i_oe, input bit i_sel, input logic [15:0] i_val,
                        input bit i_txr, input bit i_rxv, input logic [15:0] i_rxd);
        @(negedge clk);
        we       = i_we;
        oe       = i_oe;
        sel      = i_sel;
        drv_val  = i_val;
        drv_en   = i_we && !i_oe;
        tx_ready = i_txr;
        rx_valid = i_rxv;
        rx_data  = i_rxd;
        #1;
        compare_outputs();
        if (r) model_step();
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0000, 0, 0, 16'h0000);
    endtask

    task automatic cpu_write(input logic [15:0] v);
        step(1, 0, 0, v, 0, 0, 16'h0000);
    endtask

    task automatic ctrl_write(input logic [15:0] v);
        step(1, 0, 1, v, 0, 0, 16'h0000);
    endtask

    task automatic dev_push(input logic [15:0] v);
        step(0, 0, 0, 16'h0000, 0, 1, v);
    endtask

    task automatic status_expect(input string name, input logic [15:0] exp);
        step(0, 1, 1, 16'h0000, 0, 0, 16'h0000);
        chk({name, "_dut"}, bus, exp);
        chk({name, "_model"}, m_status(), exp);
        $display("status %s: bus=%h", name, bus);
    endtask

    // Asynchronous reset applied between edges; outputs must react at once
    task automatic do_reset();
        @(negedge clk);
        we = 0; oe = 0; sel = 0; drv_en = 0; tx_ready = 0; rx_valid = 0;
        r = 1'b0;
        #1;
        chk("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
        chk("rst_tx_data", tx_data, 16'h0000);
        chk("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
        tx_q.delete();
        rx_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        idle();
        idle();
        r = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_seq [3];
        r = 1'b1; we = 0; oe = 0; sel = 0; drv_en = 0; drv_val = 0;
        tx_ready = 0; rx_valid = 0; rx_data = 0;
        m_ovf = 0; m_udf = 0;

        do_reset();
        status_expect("after_reset", 16'h0000);

        // TX path
        cpu_write(16'h1111);
        cpu_write(16'h2222);
        cpu_write(16'h3333);
        status_expect("tx3", 16'h0003);
        chk("tx_head", tx_data, 16'h1111);
        exp_seq[0] = 16'h1111; exp_seq[1] = 16'h2222; exp_seq[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
            chk("tx_drain", tx_data, exp_seq[i]);
            $display("tx drain word %0d: %h", i, tx_data);
        end
        idle();
        chk("tx_empty_valid", {15'd0, tx_valid}, 16'h0000);

        // RX path
        dev_push(16'hA5A5);
        dev_push(16'h5A5A);
        status_expect("rx2", 16'h0020);
        step(0, 1, 0, 16'h0000, 0, 0, 16'h0000);
        chk("rx_read0", bus, 16'hA5A5);
        step(0, 1, 0, 16'h0000, 0, 0, 16'h0000);
        chk("rx_read1", bus, 16'h5A5A);
        status_expect("rx_empty", 16'h0000);

        // Overflow and wrap
        for (int v = 1; v <= 9; v++) cpu_write(16'(v));
        status_expect("overflow", 16'h8008);
        for (int v = 1; v <= 8; v++) begin
            step(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
            chk("ovf_drain", tx_data, 16'(v));
        end
        cpu_write(16'h0010);
        step(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
        chk("wrap_word", tx_data, 16'h0010);
        status_expect("ovf_sticky", 16'h8000);
        ctrl_write(16'h0001);
        status_expect("ovf_cleared", 16'h0000);

        // Underflow and clear
        step(0, 1, 0, 16'h0000, 0, 0, 16'h0000);
        chk("udf_bus", bus, 16'h0000);
        status_expect("underflow", 16'h4000);
        ctrl_write(16'h0001);
        status_expect("udf_cleared", 16'h0000);

        // Simultaneous push and pop on a full TX FIFO
        for (int i = 0; i < 8; i++) cpu_write(16'h0100 + 16'(i));
        status_expect("tx_full", 16'h0008);
        step(1, 0, 0, 16'hBEEF, 1, 0, 16'h0000);
        chk("full_pushpop_head", tx_data, 16'h0100);
        status_expect("tx_full_again", 16'h0008);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 16'h0000, 1, 0, 16'h0000);
            if (i == 7) chk("beef_last", tx_data, 16'hBEEF);
        end
        status_expect("tx_drained", 16'h0000);

        // RX full, then flush
        for (int i = 0; i < 8; i++) dev_push(16'h0200 + 16'(i));
        idle();
        chk("rx_full_ready", {15'd0, rx_ready}, 16'h0000);
        dev_push(16'hDEAD);
        status_expect("rx_full", 16'h0080);
        cpu_write(16'h0301);
        cpu_write(16'h0302);
        status_expect("both_loaded", 16'h0082);
        ctrl_write(16'h0002);
        status_expect("flushed", 16'h0000);
        chk("flush_rx_ready", {15'd0, rx_ready}, 16'h0001);

        // Reset mid-operation
        for (int i = 0; i < 8; i++) dev_push(16'h0400 + 16'(i));
        cpu_write(16'h0501);
        cpu_write(16'h0502);
        cpu_write(16'h0503);
        do_reset();
        status_expect("midop_reset", 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          rw  = ($urandom_range(0, 99) < 35);
            bit          ro  = ($urandom_range(0, 99) < 25);
            bit          rs  = ($urandom_range(0, 7) == 0);
            logic [15:0] rv  = 16'($urandom);
            bit          rtx = ($urandom_range(0, 99) < 40);
            bit          rrx = ($urandom_range(0, 99) < 50);
            logic [15:0] rd  = 16'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(rw, ro, rs, rv, rtx, rrx, rd);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
